match_ctrl: RTL and testbench

// - Match sequencer for pong: owns the game flow (idle, serve, rally, game over) and both scores.
// - Gates the ball engine with play_en / ball_reset and picks the serve direction.
// - Sits between the debounced start button, the ball engine's out_left/out_right, and the score display.
// - Single clock domain; game-rate timing comes from a 1-cycle tick enable, not a second clock.

---
 rtl/pong_pkg.sv | 19 +
 rtl/match_timer.sv | 50 +++++
 rtl/match_ctrl.sv | 146 ++++++++++++++
 tb/tb_match_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared pong definitions: match state encoding and serve direction constants.
package pong_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SERVE = 2'd1;
    localparam logic [1:0] ST_PLAY  = 2'd2;
    localparam logic [1:0] ST_OVER  = 2'd3;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        StIdle  = ST_IDLE,
        StServe = ST_SERVE,
        StPlay  = ST_PLAY,
        StOver  = ST_OVER
    } state_e;

endpackage

// File: rtl/match_timer.sv
// Loadable serve down-counter, advanced by the game tick while enabled.
// expired_o is high once a tick has found the count at zero (including that same cycle)
// and stays high until the next load.
module match_timer #(
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    input  logic             tick_i,
    output logic             expired_o
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             expired_q, expired_d;
    logic             expire_now;

    assign expire_now = en_i & tick_i & (count_q == '0);
    assign expired_o  = expired_q | expire_now;

    // Next count: load wins, otherwise decrement on tick until zero, then flag expiry.
    always_comb begin
        count_d   = count_q;
        expired_d = expired_q;
        if (load_i) begin
            count_d   = load_val_i;
            expired_d = 1'b0;
        end else if (en_i && tick_i) begin
            if (count_q != '0) begin
                count_d = count_q - 1'b1;
            end else begin
                expired_d = 1'b1;
            end
        end
    end

    // Counter state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            expired_q <= expired_d;
        end
    end

endmodule

// File: rtl/match_ctrl.sv
// Pong match sequencer: game flow, scoring and serve direction.
// Build option AUTO_SERVE_EN: when defined, SERVE launches on timer expiry by itself;
// otherwise an expired serve waits for a start rising edge.
module match_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE   = 9,
    parameter int unsigned SERVE_DELAY = 1500,
    parameter int unsigned TIMERWIDTH  = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       out_left,
    input  logic       out_right,
    output logic       play_en,
    output logic       ball_reset,
    output logic       serve_dir,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic       game_over,
    output logic       winner
);

    localparam logic [3:0]            WinBcd   = 4'(WIN_SCORE);
    localparam logic [TIMERWIDTH-1:0] DelayVal = TIMERWIDTH'(SERVE_DELAY);

    state_e     state_q, state_d;
    logic       start_q;
    logic [3:0] score_p1_q, score_p1_d, score_p2_q, score_p2_d;
    logic       serve_dir_q, serve_dir_d;
    logic       winner_q, winner_d;
    logic       play_en_q, ball_reset_q, game_over_q;

    logic       start_rise;
    logic       timer_load;
    logic       timer_expired;
    logic [3:0] p1_inc, p2_inc;

    assign start_rise = start & ~start_q;
    assign p1_inc     = score_p1_q + 4'd1;
    assign p2_inc     = score_p2_q + 4'd1;

    match_timer #(
        .WIDTH (TIMERWIDTH)
    ) u_timer (
        .clk_i      (clk),
        .rst_ni     (reset),
        .load_i     (timer_load),
        .load_val_i (DelayVal),
        .en_i       (state_q == StServe),
        .tick_i     (tick),
        .expired_o  (timer_expired)
    );

    // Next-state, scoring and serve-direction decisions.
    always_comb begin
        state_d     = state_q;
        score_p1_d  = score_p1_q;
        score_p2_d  = score_p2_q;
        serve_dir_d = serve_dir_q;
        winner_d    = winner_q;
        timer_load  = 1'b0;
        unique case (state_q)
            StIdle, StOver: begin
                if (start_rise) begin
                    score_p1_d  = 4'd0;
                    score_p2_d  = 4'd0;
                    serve_dir_d = ~serve_dir_q;
                    timer_load  = 1'b1;
                    state_d     = StServe;
                end
            end
            StServe: begin
`ifdef AUTO_SERVE_EN
                if (timer_expired) state_d = StPlay;
`else
                if (timer_expired && start_rise) state_d = StPlay;
`endif
            end
            StPlay: begin
                if (out_left && out_right) begin
                    // Simultaneous exits: replay the point.
                    timer_load = 1'b1;
                    state_d    = StServe;
                end else if (out_left) begin
                    score_p2_d  = p2_inc;
                    serve_dir_d = DIR_LEFT;
                    if (p2_inc == WinBcd) begin
                        winner_d = 1'b1;
                        state_d  = StOver;
                    end else begin
                        timer_load = 1'b1;
                        state_d    = StServe;
                    end
                end else if (out_right) begin
                    score_p1_d  = p1_inc;
                    serve_dir_d = DIR_RIGHT;
                    if (p1_inc == WinBcd) begin
                        winner_d = 1'b0;
                        state_d  = StOver;
                    end else begin
                        timer_load = 1'b1;
                        state_d    = StServe;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, score and registered output flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            start_q      <= 1'b0;
            score_p1_q   <= 4'd0;
            score_p2_q   <= 4'd0;
            serve_dir_q  <= DIR_LEFT;
            winner_q     <= 1'b0;
            play_en_q    <= 1'b0;
            ball_reset_q <= 1'b1;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= start;
            score_p1_q   <= score_p1_d;
            score_p2_q   <= score_p2_d;
            serve_dir_q  <= serve_dir_d;
            winner_q     <= winner_d;
            play_en_q    <= (state_d == StPlay);
            ball_reset_q <= (state_d != StPlay);
            game_over_q  <= (state_d == StOver);
        end
    end

    assign play_en    = play_en_q;
    assign ball_reset = ball_reset_q;
    assign game_over  = game_over_q;
    assign serve_dir  = serve_dir_q;
    assign score_p1   = score_p1_q;
    assign score_p2   = score_p2_q;
    assign winner     = winner_q;

endmodule

// File: tb/tb_match_ctrl.sv
// Self-checking bench for match_ctrl: directed match scenarios plus random play,
// compared against a phase/points model. Follows AUTO_SERVE_EN like the design.
module tb_match_ctrl;

    localparam int unsigned WIN = 2;
    localparam int unsigned SD  = 3;

    logic       clk = 1'b0;
    logic       reset, tick, start, out_left, out_right;
    logic       play_en, ball_reset, serve_dir, game_over, winner;
    logic [3:0] score_p1, score_p2;

    int checks = 0;
    int errors = 0;

    typedef enum {MIdle, MServe, MPlay, MOver} phase_e;
    phase_e m_phase;
    int     m_p1, m_p2, m_left;
    logic   m_dir, m_win, m_prev_start;

    match_ctrl #(
        .WIN_SCORE   (WIN),
        .SERVE_DELAY (SD),
        .TIMERWIDTH  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .start      (start),
        .out_left   (out_left),
        .out_right  (out_right),
        .play_en    (play_en),
        .ball_reset (ball_reset),
        .serve_dir  (serve_dir),
        .score_p1   (score_p1),
        .score_p2   (score_p2),
        .game_over  (game_over),
        .winner     (winner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = MIdle; m_p1 = 0; m_p2 = 0; m_left = 0;
        m_dir = 1'b0; m_win = 1'b0; m_prev_start = 1'b0;
    endtask

    // m_left counts serve ticks still needed before launch becomes possible.
    task automatic model_step(input logic t, input logic s, input logic ol, input logic orr);
        logic rise;
        rise = s && !m_prev_start;
        m_prev_start = s;
        case (m_phase)
            MIdle, MOver: if (rise) begin
                m_p1 = 0; m_p2 = 0; m_dir = !m_dir; m_left = SD + 1; m_phase = MServe;
            end
            MServe: begin
                if (t && m_left > 0) m_left--;
`ifdef AUTO_SERVE_EN
                if (m_left == 0) m_phase = MPlay;
`else
                if (m_left == 0 && rise) m_phase = MPlay;
`endif
            end
            MPlay: begin
                if (ol && orr) begin
                    m_left = SD + 1; m_phase = MServe;
                end else if (ol) begin
                    m_p2++; m_dir = 1'b0;
                    if (m_p2 == WIN) begin m_win = 1'b1; m_phase = MOver; end
                    else begin m_left = SD + 1; m_phase = MServe; end
                end else if (orr) begin
                    m_p1++; m_dir = 1'b1;
                    if (m_p1 == WIN) begin m_win = 1'b0; m_phase = MOver; end
                    else begin m_left = SD + 1; m_phase = MServe; end
                end
            end
            default: ;
        endcase
    endtask

    task automatic check_all();
        check("play_en",    {3'b0, play_en},    {3'b0, m_phase == MPlay});
        check("ball_reset", {3'b0, ball_reset}, {3'b0, m_phase != MPlay});
        check("game_over",  {3'b0, game_over},  {3'b0, m_phase == MOver});
        check("serve_dir",  {3'b0, serve_dir},  {3'b0, m_dir});
        check("winner",     {3'b0, winner},     {3'b0, m_win});
        check("score_p1",   score_p1,           4'(m_p1));
        check("score_p2",   score_p2,           4'(m_p2));
    endtask

    task automatic step(input logic t, input logic s, input logic ol, input logic orr);
        @(negedge clk);
        tick = t; start = s; out_left = ol; out_right = orr;
        @(posedge clk);
        model_step(t, s, ol, orr);
        #1;
        check_all();
    endtask

    task automatic start_pulse();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Advance from SERVE to PLAY, bounded.
    task automatic serve_to_play();
        for (int i = 0; i < 100; i++) begin
            if (m_phase == MPlay) break;
`ifdef AUTO_SERVE_EN
            step(1'b1, 1'b0, 1'b0, 1'b0);
`else
            if (m_left == 0) start_pulse();
            else step(1'b1, 1'b0, 1'b0, 1'b0);
`endif
        end
        check("reach_play", {3'b0, play_en}, 4'd1);
    endtask

    initial begin
        logic s_lvl;
        reset = 1'b0; tick = 1'b0; start = 1'b0; out_left = 1'b0; out_right = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b1;

        // Idle hold.
        for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        check("idle_ball_reset", {3'b0, ball_reset}, 4'd1);
        check("idle_play_en",    {3'b0, play_en},    4'd0);
        check("idle_scores",     {score_p1[1:0], score_p2[1:0]}, 4'd0);
        check("idle_game_over",  {3'b0, game_over},  4'd0);

        // First serve.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("serve_dir_first", {3'b0, serve_dir},  4'd1);
        check("serve_ball_rst",  {3'b0, ball_reset}, 4'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef AUTO_SERVE_EN
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            check("serve_wait", {3'b0, play_en}, 4'd0);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("launch_4th_tick", {3'b0, play_en}, 4'd1);
`else
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        start_pulse();
        check("early_start", {3'b0, play_en}, 4'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        check("hold_serve", {3'b0, play_en}, 4'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("late_start", {3'b0, play_en}, 4'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
`endif

        // Player 1 scores, then a stray out_left in SERVE.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("p1_point", score_p1, 4'd1);
        check("p1_dir",   {3'b0, serve_dir}, 4'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("ignore_out_serve", score_p2, 4'd0);

        // Simultaneous exits replay.
        serve_to_play();
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("replay_p1", score_p1, 4'd1);
        check("replay_p2", score_p2, 4'd0);
        check("replay_serve", {3'b0, ball_reset}, 4'd1);

        // Player 2 wins, then restart.
        serve_to_play();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        serve_to_play();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("win_p2",     score_p2, 4'd2);
        check("win_over",   {3'b0, game_over}, 4'd1);
        check("win_winner", {3'b0, winner},    4'd1);
        start_pulse();
        check("restart_scores", {score_p1[1:0], score_p2[1:0]}, 4'd0);
        check("restart_over",   {3'b0, game_over},  4'd0);

        // Async reset mid-PLAY.
        serve_to_play();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        check("rst_ball_reset", {3'b0, ball_reset}, 4'd1);
        @(negedge clk);
        reset = 1'b1;

        // Random play against the model.
        s_lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) s_lvl = !s_lvl;
            step(1'($urandom_range(0, 1)), s_lvl,
                 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
